alu_operand_sequencer: RTL

- Multicycle front stage that feeds the 16-bit ALU and consumes its result.
- Holds an 8x16 register file and accepts one ALU command at a time over a valid/ready handshake.
- Reads both operands, drives the ALU operand/opcode/carry-in ports, and captures the ALU result and zero/negative flags.
- Writes the result back to the destination register and updates the architectural Z/N flags.

---
 rtl/alu_operand_sequencer_pkg.sv | 26 ++
 rtl/alu_operand_sequencer_seq_regfile.sv | 55 +++++
 rtl/alu_operand_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/alu_operand_sequencer_pkg.sv
// Shared definitions for the ALU operand sequencer.
// Holds the data width, register count and index width, the ALU opcode
// constants and the sequencer state encoding.
package alu_operand_sequencer_pkg;

  localparam int SEQ_W     = 16;
  localparam int SEQ_NREGS = 8;
  localparam int SEQ_AW    = $clog2(SEQ_NREGS);

  localparam logic [2:0] OP_NEG   = 3'd0;
  localparam logic [2:0] OP_INC   = 3'd1;
  localparam logic [2:0] OP_ADC   = 3'd2;
  localparam logic [2:0] OP_ADDSH = 3'd3;
  localparam logic [2:0] OP_AND   = 3'd4;
  localparam logic [2:0] OP_OR    = 3'd5;
  localparam logic [2:0] OP_PACK  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/alu_operand_sequencer_seq_regfile.sv
// NREGS x W register file for the operand sequencer.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   ld_en/ld_addr/ld_data           direct load write
//   wb_en/wb_addr/wb_data           writeback write (wins over a load to the same index)
//   rd_en/rd_addr_a/rd_addr_b       capture strobe and indices for the two operand reads
//   rd_data_a/rd_data_b             registered operand read data
//   dbg_addr/dbg_data               combinational debug read
module alu_operand_sequencer_seq_regfile
  import alu_operand_sequencer_pkg::*;
#(
  parameter int NREGS = SEQ_NREGS,
  parameter int W     = SEQ_W,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [W-1:0]  wb_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [W-1:0]  rd_data_a,
  output logic [W-1:0]  rd_data_b,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data
);

  logic [W-1:0] rf [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (wb_en && (wb_addr == AW'(i)))      rf[i] <= wb_data;
        else if (ld_en && (ld_addr == AW'(i))) rf[i] <= ld_data;
      end
      // Reads sample the pre-edge contents, so a same-edge load is not seen.
      if (rd_en) begin
        rd_data_a <= rf[rd_addr_a];
        rd_data_b <= rf[rd_addr_b];
      end
    end
  end

  assign dbg_data = rf[dbg_addr];

endmodule

// File: rtl/alu_operand_sequencer.sv
// Multicycle operand sequencer in front of a combinational 16-bit ALU.
// Accepts one command per valid/ready handshake, reads both operands,
// drives the ALU, captures its result/flags and writes the result back.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake (ready only in IDLE)
//   cmd_opc/cmd_rd/cmd_rs/cmd_rt     opcode, destination and source indices
//   cmd_cin                          carry-in for add-with-carry
//   ld_en/ld_addr/ld_data            direct register load
//   alu_a/alu_b/alu_c/alu_opc        to the ALU
//   alu_w/alu_zer/alu_neg            from the ALU
//   done/err                         completion pulse, reserved-opcode error
//   result/flag_z/flag_n             last written-back result and flags
//   dbg_addr/dbg_data                combinational register debug read
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// READ  | operand registers capture rf[rs], rf[rt], cin, opc
// EXEC  | ALU outputs valid; result and flags captured, done raised
// WB    | done/err visible; rf[rd] written unless opcode reserved
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int NREGS = SEQ_NREGS,
  parameter int W     = SEQ_W,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_opc,
  input  logic [AW-1:0] cmd_rd,
  input  logic [AW-1:0] cmd_rs,
  input  logic [AW-1:0] cmd_rt,
  input  logic          cmd_cin,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [W-1:0]  ld_data,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic          alu_c,
  output logic [2:0]    alu_opc,
  input  logic [W-1:0]  alu_w,
  input  logic          alu_zer,
  input  logic          alu_neg,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  result,
  output logic          flag_z,
  output logic          flag_n,
  input  logic [AW-1:0] dbg_addr,
  output logic [W-1:0]  dbg_data
);

  seq_state_e    state;
  logic [2:0]    opc_q;
  logic [AW-1:0] rd_q;
  logic [AW-1:0] rs_q;
  logic [AW-1:0] rt_q;
  logic          cin_q;
  logic          rf_rd_en;
  logic          rf_wb_en;

  assign rf_rd_en = (state == ST_READ);
  // err is high exactly during WB of a reserved opcode, which suppresses the write.
  assign rf_wb_en = (state == ST_WB) && !err;

  // result is loaded from the ALU in EXEC, so it also serves as the writeback staging value.
  alu_operand_sequencer_seq_regfile #(
    .NREGS (NREGS),
    .W     (W)
  ) u_seq_regfile (
    .clk       (clk),
    .rst       (rst),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .wb_en     (rf_wb_en),
    .wb_addr   (rd_q),
    .wb_data   (result),
    .rd_en     (rf_rd_en),
    .rd_addr_a (rs_q),
    .rd_addr_b (rt_q),
    .rd_data_a (alu_a),
    .rd_data_b (alu_b),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      alu_c     <= 1'b0;
      alu_opc   <= OP_NEG;
      opc_q     <= OP_NEG;
      rd_q      <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      cin_q     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            opc_q     <= cmd_opc;
            rd_q      <= cmd_rd;
            rs_q      <= cmd_rs;
            rt_q      <= cmd_rt;
            cin_q     <= cmd_cin;
            cmd_ready <= 1'b0;
            state     <= ST_READ;
          end
        end
        ST_READ: begin
          alu_c   <= cin_q;
          alu_opc <= opc_q;
          state   <= ST_EXEC;
        end
        ST_EXEC: begin
          // done/err are raised here so they are visible during the WB cycle.
          done <= 1'b1;
          err  <= (alu_opc == OP_RSVD);
          if (alu_opc != OP_RSVD) begin
            result <= alu_w;
            flag_z <= alu_zer;
            flag_n <= alu_neg;
          end
          state <= ST_WB;
        end
        ST_WB: begin
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
